seq_reader: RTL

Sequence reader that drains a run of entries from the 32×8 pattern memory and presents them one at a time on a valid/ready output stream. It owns the memory's read port (`r_en`, `r_addr`, `r_data`), which has one cycle of latency. It sits between the pattern memory and the playback/display logic. The game controller starts a run with a base address and length, and gets a done pulse when the last entry has been accepted.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_reader_if.sv | 26 ++
 rtl/seq_reader_gap_timer.sv | 27 ++
 rtl/seq_reader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the pattern memory, sequence reader and game controller.
// Holds memory geometry, the reader FSM encoding and the length clamp helper.
package seq_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
        S_GAP
    } state_t;

    // A run can never be longer than the memory itself.
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len
    );
        if (len > LEN_W'(MEM_DEPTH))
            return LEN_W'(MEM_DEPTH);
        return len;
    endfunction

endpackage

// File: rtl/seq_reader_if.sv
// Valid/ready entry stream from the sequence reader to the playback logic.
// master: o_Data/o_Valid/o_Last out, i_Ready in; slave: the reverse.
interface seq_reader_if
    import seq_pkg::*;
();

    logic [DATA_W-1:0] o_Data;
    logic              o_Valid;
    logic              o_Last;
    logic              i_Ready;

    modport master (
        output o_Data,
        output o_Valid,
        output o_Last,
        input  i_Ready
    );

    modport slave (
        input  o_Data,
        input  o_Valid,
        input  o_Last,
        output i_Ready
    );

endinterface

// File: rtl/seq_reader_gap_timer.sv
// gap_timer: loadable down-counter with load, enable and a zero flag.
// Ports: i_Clk, i_Rst_L, i_Load/i_Value (load), i_En (count down), o_Zero.
module gap_timer #(
    parameter int W = 16
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         i_Load,
    input  logic [W-1:0] i_Value,
    input  logic         i_En,
    output logic         o_Zero
);

    logic [W-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            count <= '0;
        else if (i_Load)
            count <= i_Value;
        else if (i_En && count != '0)
            count <= count - 1'b1;
    end

    assign o_Zero = (count == '0);

endmodule

// File: rtl/seq_reader.sv
// seq_reader: drains a run of pattern-memory entries onto a valid/ready stream.
// Ports: i_Clk, i_Rst_L, i_Start/i_Base/i_Length/i_Abort, read port, stream, o_Busy, o_Done.
module seq_reader
    import seq_pkg::*;
#(
    parameter int GAP_CYCLES = 0,
    parameter int GAP_W      = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Start,
    input  logic [ADDR_W-1:0] i_Base,
    input  logic [LEN_W-1:0]  i_Length,
    input  logic              i_Abort,
    output logic              o_r_en,
    output logic [ADDR_W-1:0] o_r_addr,
    input  logic [DATA_W-1:0] i_r_data,
    seq_reader_if.master      stream,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam bit HAS_GAP = (GAP_CYCLES != 0);
    // The timer is loaded on the transfer edge, so GAP spans value+1 cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_d;
    logic              last_d;
    logic              done_d;
    logic              xfer;
    logic              gap_load;
    logic              gap_en;
    logic              gap_zero;

    gap_timer #(.W(GAP_W)) u_gap (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Load  (gap_load),
        .i_Value (GAP_LOAD),
        .i_En    (gap_en),
        .o_Zero  (gap_zero)
    );

    assign xfer = stream.o_Valid && stream.i_Ready;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        data_d   = stream.o_Data;
        last_d   = stream.o_Last;
        done_d   = 1'b0;
        gap_load = 1'b0;
        gap_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_Start && !i_Abort) begin
                    base_d = i_Base;
                    len_d  = clamp_len(i_Length);
                    idx_d  = '0;
                    if (len_d == '0)
                        done_d = 1'b1;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = i_r_data;
                last_d  = (idx_q == len_q - 1'b1);
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (xfer) begin
                    if (stream.o_Last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (HAS_GAP) begin
                            state_d  = S_GAP;
                            gap_load = 1'b1;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_GAP: begin
                gap_en = 1'b1;
                if (gap_zero)
                    state_d = S_READ;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats any transfer in the same cycle.
        if (i_Abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q        <= S_IDLE;
            base_q         <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            o_r_en         <= 1'b0;
            o_r_addr       <= '0;
            stream.o_Data  <= '0;
            stream.o_Valid <= 1'b0;
            stream.o_Last  <= 1'b0;
            o_Busy         <= 1'b0;
            o_Done         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            o_r_en         <= (state_d == S_READ);
            // 5-bit sum wraps the run around the end of memory.
            if (state_d == S_READ)
                o_r_addr <= base_d + idx_d[ADDR_W-1:0];
            stream.o_Data  <= data_d;
            stream.o_Valid <= (state_d == S_PRESENT);
            stream.o_Last  <= last_d;
            o_Busy         <= (state_d != S_IDLE);
            o_Done         <= done_d;
        end
    end

endmodule
